// File: rtl/uart_tx_rr_arbiter.sv
// Round-robin arbiter sharing one UART TX byte stream among NUM_SRC AXI-Stream sources.
// Define ARB_TIMEOUT_EN to revoke a grant whose source stalls for TIMEOUT_CYCLES cycles.
module uart_tx_rr_arbiter #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned IDW           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM_SRC*8-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]   s_tvalid,
  input  logic [NUM_SRC-1:0]   s_tlast,
  output logic [NUM_SRC-1:0]   s_tready,
  output logic [7:0]           m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  input  logic                 m_tready,
  output logic [IDW-1:0]       m_tid,
`ifdef ARB_TIMEOUT_EN
  output logic                 timeout_pulse,
`endif
  output logic                 busy
);

  typedef enum logic {StIdle, StXfer} state_e;

  state_e         state_q;
  // Holds the current grant in XFER and serves as the last-grant pointer in IDLE.
  logic [IDW-1:0] gnt_q;
  logic [7:0]     beat_q, beat_d;
  logic [IDW-1:0] pick, cand;
  logic           found;
  logic           accept;
  logic           burst_end;
  logic           timeout;

  always_comb begin
    pick  = gnt_q;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = IDW'((32'(gnt_q) + k) % NUM_SRC);
      if (!found && s_tvalid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign accept    = (state_q == StXfer) && s_tvalid[gnt_q] && m_tready;
  assign beat_d    = beat_q + 8'd1;
  assign burst_end = s_tlast[gnt_q] || (beat_d == 8'(MAX_BURST));

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q;

  assign timeout = (state_q == StXfer) && !s_tvalid[gnt_q] &&
                   (idle_q == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_pulse = timeout;

  always_ff @(posedge aclk) begin
    if (!aresetn || (state_q != StXfer) || s_tvalid[gnt_q] || timeout) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= StIdle;
      gnt_q   <= IDW'(NUM_SRC - 1);
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            gnt_q   <= pick;
            beat_q  <= '0;
            state_q <= StXfer;
          end
        end
        StXfer: begin
          if (accept) beat_q <= beat_d;
          if ((accept && burst_end) || timeout) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    s_tready = '0;
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tid    = '0;
    busy     = 1'b0;
    if (state_q == StXfer) begin
      s_tready[gnt_q] = m_tready;
      m_tdata         = s_tdata[{gnt_q, 3'b000} +: 8];
      m_tvalid        = s_tvalid[gnt_q];
      m_tlast         = s_tlast[gnt_q];
      m_tid           = gnt_q;
      busy            = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// Bench for uart_tx_rr_arbiter: per-source byte queues feed the DUT, a grant-level model is
// compared every cycle, and the accepted-beat log is pinned against hand-computed sequences.
module tb_uart_tx_rr_arbiter;
  localparam int N  = 4;
  localparam int MB = 16;
  localparam int TO = 8;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [N*8-1:0] s_tdata;
  logic [N-1:0]   s_tvalid, s_tlast, s_tready;
  logic [7:0]     m_tdata;
  logic           m_tvalid, m_tlast, m_tready, busy;
  logic [1:0]     m_tid;
`ifdef ARB_TIMEOUT_EN
  logic           timeout_pulse;
`endif

  uart_tx_rr_arbiter #(
    .NUM_SRC       (N),
    .MAX_BURST     (MB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tlast      (m_tlast),
    .m_tready     (m_tready),
    .m_tid        (m_tid),
`ifdef ARB_TIMEOUT_EN
    .timeout_pulse(timeout_pulse),
`endif
    .busy         (busy)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  // Source-side stimulus: per-source byte queues {last, data}.
  logic [8:0] mem [N][32];
  int hd [N];
  int tl [N];
  logic rst_n = 1'b0;
  logic mready = 1'b1;

  // Accepted-beat log.
  int lg_tid [64];
  int lg_data [64];
  int lg_last [64];
  int lg_edge [64];
  int lg_n = 0;

  // Grant-level model: owner (-1 = none), pointer, beats in grant, stalled cycles.
  int own = -1, ptr = N - 1, beats = 0, idle = 0;
  bit model_ok = 0;
  int acc_src = -1;
  bit flush = 0;
  int dut_pulse_edge = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
    end
  endtask

  task automatic push(input int src, input int data, input bit last);
    mem[src][tl[src]] = {last, 8'(data)};
    tl[src]++;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      if (hd[i] < tl[i]) begin
        s_tvalid[i]       = 1'b1;
        s_tdata[i*8 +: 8] = mem[i][hd[i]][7:0];
        s_tlast[i]        = mem[i][hd[i]][8];
      end else begin
        s_tvalid[i]       = 1'b0;
        s_tdata[i*8 +: 8] = 8'h00;
        s_tlast[i]        = 1'b0;
      end
    end
    m_tready = mready;
    aresetn  = rst_n;
  endtask

  task automatic check_and_step();
    logic [N-1:0] exp_rdy;
    bit exp_v;
    bit found;
    int idx;
    if (model_ok) begin
      exp_v   = (own >= 0) && s_tvalid[own];
      exp_rdy = '0;
      if (own >= 0) exp_rdy[own] = m_tready;
      chk("busy", 32'(busy), 32'(own >= 0));
      chk("m_tvalid", 32'(m_tvalid), 32'(exp_v));
      chk("m_tid", 32'(m_tid), (own >= 0) ? own : 0);
      chk("s_tready", 32'(s_tready), 32'(exp_rdy));
      if (exp_v) begin
        chk("m_tdata", 32'(m_tdata), 32'(s_tdata[own*8 +: 8]));
        chk("m_tlast", 32'(m_tlast), 32'(s_tlast[own]));
      end
`ifdef ARB_TIMEOUT_EN
      chk("timeout_pulse", 32'(timeout_pulse),
          32'((own >= 0) && !s_tvalid[own] && (idle == TO - 1)));
      if (timeout_pulse) dut_pulse_edge = edges + 1;
`endif
    end
    acc_src = -1;
    flush   = 0;
    if (!aresetn) begin
      own = -1; ptr = N - 1; beats = 0; idle = 0; model_ok = 1; flush = 1;
    end else if (model_ok) begin
      if (own < 0) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          idx = (ptr + k) % N;
          if (!found && s_tvalid[idx]) begin
            found = 1; own = idx; ptr = idx; beats = 0; idle = 0;
          end
        end
      end else if (s_tvalid[own]) begin
        idle = 0;
        if (m_tready) begin
          acc_src = own;
          if (lg_n < 64) begin
            lg_tid[lg_n]  = own;
            lg_data[lg_n] = int'(s_tdata[own*8 +: 8]);
            lg_last[lg_n] = int'(s_tlast[own]);
            lg_edge[lg_n] = edges + 1;
            lg_n++;
          end
          beats++;
          if (s_tlast[own] || beats == MB) own = -1;
        end
      end else begin
`ifdef ARB_TIMEOUT_EN
        idle++;
        if (idle == TO) begin
          own = -1; idle = 0;
        end
`endif
      end
    end
  endtask

  task automatic cycle();
    @(negedge aclk);
    check_and_step();
    @(posedge aclk);
    #1;
    edges++;
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        hd[i] = 0; tl[i] = 0;
      end
    end else if (acc_src >= 0) begin
      hd[acc_src]++;
    end
    apply();
  endtask

  task automatic run_until(input int n, input int budget);
    int b = 0;
    while (lg_n < n && b < budget) begin
      cycle();
      b++;
    end
    if (lg_n < n) chk("wait_beats", lg_n, n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mready = 1'b1;
    apply();
    cycle();
    cycle();
    rst_n = 1'b1;
    apply();
    lg_n = 0;
  endtask

  task automatic exp_beat(input int i, input int tid, input int data, input int last);
    chk("log_tid", lg_tid[i], tid);
    chk("log_data", lg_data[i], data);
    chk("log_last", lg_last[i], last);
  endtask

  task automatic exp_gap(input int i, input int gap);
    chk("log_gap", lg_edge[i] - lg_edge[i-1], gap);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      hd[i] = 0; tl[i] = 0;
    end
    apply();

    // Two 3-byte packets from sources 0 and 2.
    do_reset();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_tid", 32'(m_tid), 0);
    push(0, 8'h10, 0); push(0, 8'h11, 0); push(0, 8'h12, 1);
    push(2, 8'h20, 0); push(2, 8'h21, 0); push(2, 8'h22, 1);
    apply();
    run_until(6, 40);
    exp_beat(0, 0, 8'h10, 0); exp_beat(1, 0, 8'h11, 0); exp_beat(2, 0, 8'h12, 1);
    exp_beat(3, 2, 8'h20, 0); exp_beat(4, 2, 8'h21, 0); exp_beat(5, 2, 8'h22, 1);
    exp_gap(1, 1); exp_gap(2, 1); exp_gap(3, 2); exp_gap(4, 1);

    // All four sources requesting 1-byte packets: strict rotation with a bubble each grant.
    do_reset();
    for (int i = 0; i < N; i++) begin
      push(i, 8'h40 + i * 16, 1);
      push(i, 8'h41 + i * 16, 1);
    end
    apply();
    run_until(8, 60);
    for (int j = 0; j < 8; j++) begin
      exp_beat(j, j % 4, 8'h40 + (j % 4) * 16 + j / 4, 1);
      if (j > 0) exp_gap(j, 2);
    end

    // 20-byte packet from source 1 split by MAX_BURST around source 3's packet.
    do_reset();
    for (int k = 0; k < 20; k++) push(1, 8'h80 + k, k == 19);
    push(3, 8'hC0, 0); push(3, 8'hC1, 1);
    apply();
    run_until(22, 100);
    for (int j = 0; j < 16; j++) exp_beat(j, 1, 8'h80 + j, 0);
    exp_beat(16, 3, 8'hC0, 0); exp_beat(17, 3, 8'hC1, 1);
    for (int j = 18; j < 22; j++) exp_beat(j, 1, 8'h90 + j - 18, int'(j == 21));
    exp_gap(16, 2); exp_gap(18, 2);

    // Backpressure pattern 1,0,0,1 on a 4-byte packet from source 0.
    do_reset();
    for (int k = 0; k < 4; k++) push(0, 8'hA0 + k, k == 3);
    apply();
    cycle();
    mready = 1'b1; apply(); cycle();
    mready = 1'b0; apply(); cycle();
    mready = 1'b0; apply(); cycle();
    mready = 1'b1; apply();
    run_until(4, 20);
    for (int j = 0; j < 4; j++) exp_beat(j, 0, 8'hA0 + j, int'(j == 3));
    exp_gap(1, 3); exp_gap(2, 1);

    // One-cycle reset during byte 2 of a source-2 packet.
    do_reset();
    push(2, 8'h50, 0); push(2, 8'h51, 0); push(2, 8'h52, 1);
    apply();
    run_until(1, 20);
    rst_n = 1'b0;
    apply();
    rst_n = 1'b1;
    cycle();
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_tready", 32'(s_tready), 0);
    chk("rst_busy", 32'(busy), 0);
    lg_n = 0;
    push(3, 8'hD0, 1); push(0, 8'hE0, 1);
    apply();
    run_until(2, 20);
    exp_beat(0, 0, 8'hE0, 1); exp_beat(1, 3, 8'hD0, 1);

`ifdef ARB_TIMEOUT_EN
    // Source 1 stalls after one byte without tlast; grant revoked, source 2 served next.
    do_reset();
    push(1, 8'h61, 0); push(2, 8'h71, 1);
    apply();
    run_until(1, 10);
    run_until(2, 30);
    exp_beat(0, 1, 8'h61, 0); exp_beat(1, 2, 8'h71, 1);
    chk("timeout_gap", dut_pulse_edge - lg_edge[0], TO);
`endif

    cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_rr_arbiter.md
Name: uart_tx_rr_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter among NUM_SRC AXI-Stream byte sources.
- Grants one source at a time and holds the grant for a whole packet (until tlast) or until MAX_BURST beats, whichever comes first.
- Sits between the per-client AXIS byte streams and the single AXIS-to-UART TX serializer; m_tid tags each beat with its source.

Parameters:
- NUM_SRC, 4, number of requesting AXIS sources (2..16).
- MAX_BURST, 16, maximum beats per grant before forced re-arbitration (1..255).
- TIMEOUT_CYCLES, 1024, idle-valid cycles before grant is revoked (used only with ARB_TIMEOUT_EN).

Ports:
- aclk  input  1  clock.
- aresetn  input  1  reset; synchronous, active-low; clock aclk.
- s_tdata  input  NUM_SRC*8  source byte data; source i occupies bits [8i+7:8i].
- s_tvalid  input  NUM_SRC  per-source valid.
- s_tlast  input  NUM_SRC  per-source end-of-packet.
- s_tready  output  NUM_SRC  per-source ready.
- m_tdata  output  8  byte to UART TX.
- m_tvalid  output  1  valid to UART TX.
- m_tlast  output  1  tlast of the granted source.
- m_tready  input  1  UART TX ready.
- m_tid  output  IDW  granted source index; IDW = max(1, $clog2(NUM_SRC)).
- busy  output  1  high while a grant is held (XFER state).

Behaviour:
- Reset values:
  - State IDLE.
  - s_tready all 0, m_tvalid 0, m_tdata 0, m_tlast 0, m_tid 0, busy 0.
  - Last-grant pointer = NUM_SRC-1, so source 0 has first priority.
  - Beat counter 0.
- State IDLE:
  - If any s_tvalid is high, pick the first requester searching upward from (last_grant+1) mod NUM_SRC, with wrap-around.
  - Register the choice into gnt and last_grant, clear the beat counter, and move to XFER next cycle.
  - If no requests, stay in IDLE.
  - No outputs are active in IDLE, so arbitration costs exactly 1 bubble cycle per grant.
- State XFER (combinational pass-through of source gnt):
  - m_tdata = s_tdata[gnt], m_tvalid = s_tvalid[gnt], m_tlast = s_tlast[gnt], m_tid = gnt.
  - s_tready[gnt] = m_tready; every other s_tready = 0.
  - busy = 1.
  - m_tdata and m_tlast are don't-care when m_tvalid = 0; the bench checks them only on valid.
- A beat is accepted when m_tvalid & m_tready; the beat counter increments on each accepted beat.
- Release (XFER -> IDLE on the cycle after the accepting edge) when either:
  - the accepted beat has s_tlast[gnt] = 1, or
  - the beat counter reaches MAX_BURST on this accept.
  - Both at once count as a single release.
- After release:
  - The next IDLE search starts from gnt+1.
  - A source cut off by MAX_BURST mid-packet resumes at a later grant; m_tid distinguishes interleaved fragments.
- Other boundary conditions:
  - A non-granted source that asserts and drops tvalid while in XFER is never seen and must not affect state.
  - A granted source dropping tvalid mid-packet keeps the grant (see Optional Feature).
  - Single requester: it is re-granted after each 1-cycle IDLE bubble.
  - NUM_SRC = 2 wraps correctly 1 -> 0.
- Reset asserted mid-transfer: next cycle IDLE, all readies 0, pointer back to NUM_SRC-1. The in-flight beat is dropped; the upstream must also be reset.
- Data is never duplicated or reordered within a source.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in XFER while s_tvalid[gnt] = 0 and clears on any cycle with s_tvalid[gnt] = 1.
  - When it reaches TIMEOUT_CYCLES, the grant is released to IDLE as if tlast had been seen.
  - Output timeout_pulse (1 bit, present only with the macro) is high for exactly that one cycle.
- Undefined:
  - No counter and no timeout_pulse port.
  - A stalled granted source holds the arbiter indefinitely until tlast or MAX_BURST.

Test Plan:
- Sources 0 and 2 each send a 3-byte packet (0x10,0x11,0x12 / 0x20,0x21,0x22), m_tready = 1 -> source 0 bytes first with m_tid = 0, m_tlast on 0x12; one idle cycle; then source 2 bytes with m_tid = 2.
- All 4 sources continuously request 1-byte packets -> grant order 0,1,2,3,0,1... with one bubble between grants.
- Source 1 sends a 20-byte packet, MAX_BURST = 16, source 3 also requesting -> 16 bytes from 1 (m_tlast = 0 on 16th); then source 3's packet; then the remaining 4 bytes from 1 with m_tlast on byte 20.
- m_tready toggles 1,0,0,1 during a 4-byte packet from source 0 -> s_tready[0] mirrors m_tready, bytes emerge unchanged and in order, no other s_tready ever high.
- aresetn pulled low for 1 cycle during byte 2 of a source-2 packet -> next cycle m_tvalid = 0, s_tready = 0; the following request from source 3 alongside source 0 grants source 0 first.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8: source 1 sends 1 byte without tlast then drops valid -> timeout_pulse 8 cycles after the last valid, then return to IDLE; pending source 2 granted next.
